// File: rtl/pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_unit_pkg
// Shared types and constants for the program-counter unit.
//   pc_state_e           : BOOT / RUN / HALT sequencing states
//   PC_INC_WORD          : sequential step for 32-bit instructions
//   PC_INC_HALF          : sequential step for compressed instructions
//   DEFAULT_RESET_VECTOR : PC after reset
//   DEFAULT_TRAP_VECTOR  : PC on trap or misaligned branch target
// ---------------------------------------------------------------------------
package pc_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [2:0]  PC_INC_WORD = 3'd4;
  localparam logic [2:0]  PC_INC_HALF = 3'd2;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_adder.sv
// ---------------------------------------------------------------------------
// pc_adder
// XLEN-wide wrap-around adder producing the sequential successor of the PC.
//   pc_i  : current PC
//   inc_i : increment (2 or 4)
//   sum_o : pc_i + inc_i modulo 2^XLEN
// ---------------------------------------------------------------------------
module pc_adder #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [2:0]      inc_i,
  output logic [XLEN-1:0] sum_o
);

  // Carry out of the top bit is dropped so 0xFFFF_FFFC + 4 wraps to 0.
  assign sum_o = pc_i + {{(XLEN-3){1'b0}}, inc_i};

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Holds the architectural PC, chooses the next PC (increment, branch/jump
// redirect, trap redirect), presents it to fetch over valid/ready, supports
// halt/resume and counts accepted fetches.
//
// Optional feature macro: PC_UNIT_COMPRESSED_EN
//   defined   : adds is_compressed_i, step is 2 or 4, alignment check on [0]
//   undefined : step is always 4, alignment check on [1:0]
//
// Ports:
//   clk_i, rst_ni      : clock (rising edge), async active-low reset
//   fetch_ready_i      : fetch stage accepts pc_o this cycle
//   stall_i            : hold the PC for a hazard
//   branch_taken_i     : redirect to branch_target_i
//   branch_target_i    : redirect address
//   trap_i             : redirect to TRAP_VECTOR
//   halt_i / resume_i  : enter / leave HALT
//   is_compressed_i    : (macro only) current instruction is 16-bit
//   pc_o               : current PC
//   next_seq_pc_o      : pc_o + step, wrapping
//   pc_valid_o         : pc_o is a valid fetch request
//   misaligned_o       : one-cycle pulse after a misaligned branch target
//   fetch_count_o      : number of accepted fetches, wrapping
// ---------------------------------------------------------------------------
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_ready_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic             trap_i,
  input  logic             halt_i,
  input  logic             resume_i,
`ifdef PC_UNIT_COMPRESSED_EN
  input  logic             is_compressed_i,
`endif
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  next_seq_pc_o,
  output logic             pc_valid_o,
  output logic             misaligned_o,
  output logic [CNT_W-1:0] fetch_count_o
);

  pc_state_e        state_q;
  logic [XLEN-1:0]  pc_q;
  logic             pc_valid_q;
  logic             misaligned_q;
  logic [CNT_W-1:0] fetch_count_q;

  logic [2:0]       pc_inc;
  logic             target_misaligned;
  logic             fetch_accept;

`ifdef PC_UNIT_COMPRESSED_EN
  assign pc_inc            = is_compressed_i ? PC_INC_HALF : PC_INC_WORD;
  assign target_misaligned = branch_target_i[0];
`else
  assign pc_inc            = PC_INC_WORD;
  assign target_misaligned = |branch_target_i[1:0];
`endif

  // A redirect or stall in the same cycle cancels the handshake; pc_valid_q
  // is only set in RUN, so this can never fire in BOOT or HALT.
  assign fetch_accept = pc_valid_q & fetch_ready_i & ~stall_i
                        & ~trap_i & ~branch_taken_i;

  pc_adder #(
    .XLEN (XLEN)
  ) u_pc_adder (
    .pc_i  (pc_q),
    .inc_i (pc_inc),
    .sum_o (next_seq_pc_o)
  );

  // Sequencer and PC register. In RUN the priority is trap, branch, halt,
  // hold, increment. In HALT only trap and resume are observed, trap first.
  // misaligned_q defaults low every cycle so it can only pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_valid_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      misaligned_q <= 1'b0;
      if (fetch_accept) begin
        fetch_count_q <= fetch_count_q + CNT_W'(1);
      end
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          if (trap_i) begin
            pc_q <= TRAP_VECTOR;
          end else if (branch_taken_i) begin
            if (target_misaligned) begin
              pc_q         <= TRAP_VECTOR;
              misaligned_q <= 1'b1;
            end else begin
              pc_q <= branch_target_i;
            end
          end else if (halt_i) begin
            state_q    <= HALT;
            pc_valid_q <= 1'b0;
          end else if (!stall_i && fetch_ready_i) begin
            pc_q <= next_seq_pc_o;
          end
        end
        HALT: begin
          if (trap_i) begin
            pc_q       <= TRAP_VECTOR;
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
          end else if (resume_i) begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign pc_valid_o    = pc_valid_q;
  assign misaligned_o  = misaligned_q;
  assign fetch_count_o = fetch_count_q;

endmodule
